// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: N-digit BCD up/down counter with parallel load and a multiplexed
// 7-segment driver (leading-zero blanking, selectable segment/select polarity).
module seg7_mux_counter #(
  parameter int NUM_DIGITS     = 3,
  parameter int TICK_DIV       = 1000000,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   transistor,
  output logic [6:0]              d7sp
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW != 0 ? {NUM_DIGITS{1'b1}} : '0;

  logic [TW-1:0]           r_tick;
  logic [RW-1:0]           r_ref;
  logic [SW-1:0]           r_scan;
  logic [4*NUM_DIGITS-1:0] r_count;
  logic                    r_wrap;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [6:0]              r_seg;
  logic                    w_tick_tc, w_tick, w_ref_tc, w_carry, w_z, w_bl;
  logic [4*NUM_DIGITS-1:0] w_next, w_load_sat;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_dig;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b0111111;
      4'd1: dec = 7'b0000110;
      4'd2: dec = 7'b1011011;
      4'd3: dec = 7'b1001111;
      4'd4: dec = 7'b1100110;
      4'd5: dec = 7'b1101101;
      4'd6: dec = 7'b1111101;
      4'd7: dec = 7'b0000111;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1101111;
      default: dec = 7'b0000000;
    endcase
  endfunction

  assign w_tick_tc = r_tick == TW'(TICK_DIV - 1);
  assign w_tick    = en & w_tick_tc;
  assign w_ref_tc  = r_ref == RW'(REFRESH_DIV - 1);
  assign w_dig     = 4'(r_count >> {r_scan, 2'b00});
  assign w_bl      = 1'(w_blank >> r_scan);

  // Ripple carry/borrow through the digits; the carry out of the top digit is the wrap.
  always_comb begin
    w_carry    = 1'b1;
    w_next     = r_count;
    w_load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_sat[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd9 : load_val[4*i +: 4];
      if (w_carry) begin
        w_next[4*i +: 4] = up_dn ? (r_count[4*i +: 4] == 4'd9 ? 4'd0 : r_count[4*i +: 4] + 4'd1)
                                 : (r_count[4*i +: 4] == 4'd0 ? 4'd9 : r_count[4*i +: 4] - 4'd1);
        w_carry = up_dn ? r_count[4*i +: 4] == 4'd9 : r_count[4*i +: 4] == 4'd0;
      end
    end
  end

  always_comb begin
    w_z     = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_z        = w_z & (r_count[4*i +: 4] == 4'd0);
      w_blank[i] = blank_lz && i != 0 && w_z;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick  <= '0;
      r_ref   <= '0;
      r_scan  <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sel   <= SEL_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      r_ref <= w_ref_tc ? '0 : r_ref + 1'b1;
      if (w_ref_tc)
        r_scan <= r_scan == SW'(NUM_DIGITS - 1) ? '0 : r_scan + 1'b1;
      if (load) begin
        r_count <= w_load_sat;
        r_tick  <= '0;
        r_wrap  <= 1'b0;
      end else begin
        if (en)
          r_tick <= w_tick_tc ? '0 : r_tick + 1'b1;
        if (w_tick)
          r_count <= w_next;
        r_wrap <= w_tick & w_carry;
      end
      r_sel <= (NUM_DIGITS'(1) << r_scan) ^ SEL_OFF;
      r_seg <= (w_bl ? 7'h00 : dec(w_dig)) ^ SEG_OFF;
    end
  end

  assign count_bcd  = r_count;
  assign wrap       = r_wrap;
  assign transistor = r_sel;
  assign d7sp       = r_seg;
endmodule

// File: tb/tb_seg7_mux_counter.sv
// tb_seg7_mux_counter: random stimulus against a decimal-integer reference model,
// driving an active-high and an active-low instance from the same inputs.
module tb_seg7_mux_counter;
  localparam int ND = 3, TD = 4, RD = 2, MAXV = 999;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] cnt_h, cnt_l;
  logic        wrap_h, wrap_l;
  logic [2:0]  sel_h, sel_l;
  logic [6:0]  seg_h, seg_l;

  int n_vec = 0, n_err = 0;
  int m_cnt, m_tick, m_ref, m_scan;
  logic m_wrap;
  logic [2:0] e_sel;
  logic [6:0] e_seg;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_mux_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .REFRESH_DIV(RD),
                     .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .blank_lz(blank_lz), .count_bcd(cnt_h), .wrap(wrap_h), .transistor(sel_h), .d7sp(seg_h));

  seg7_mux_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .REFRESH_DIV(RD),
                     .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .blank_lz(blank_lz), .count_bcd(cnt_l), .wrap(wrap_l), .transistor(sel_l), .d7sp(seg_l));

  always #5 clk = ~clk;

  function automatic int p10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    for (int i = 0; i < ND; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int sat_val(input logic [11:0] lv);
    int v = 0;
    for (int i = 0; i < ND; i++) begin
      int n;
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p10(i);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_ref = 0; m_scan = 0; m_wrap = 1'b0;
    e_sel = 3'b000; e_seg = 7'h00;
  endtask

  // One clock of the reference: outputs reflect the pre-edge digit and value.
  task automatic model_step();
    int d;
    d = (m_cnt / p10(m_scan)) % 10;
    e_sel = 3'(1 << m_scan);
    e_seg = (blank_lz && m_scan > 0 && m_cnt < p10(m_scan)) ? 7'h00 : seg_tab[d];
    if (m_ref == RD - 1) begin
      m_ref = 0;
      m_scan = (m_scan + 1) % ND;
    end else m_ref++;
    m_wrap = 1'b0;
    if (load) begin
      m_cnt = sat_val(load_val);
      m_tick = 0;
    end else if (en) begin
      if (m_tick == TD - 1) begin
        m_tick = 0;
        if (up_dn) begin
          m_wrap = m_cnt == MAXV;
          m_cnt = m_wrap ? 0 : m_cnt + 1;
        end else begin
          m_wrap = m_cnt == 0;
          m_cnt = m_wrap ? MAXV : m_cnt - 1;
        end
      end else m_tick++;
    end
  endtask

  task automatic check_all();
    chk("count",   cnt_h,  to_bcd(m_cnt));
    chk("wrap",    wrap_h, m_wrap);
    chk("sel",     sel_h,  e_sel);
    chk("seg",     seg_h,  e_seg);
    chk("count_n", cnt_l,  to_bcd(m_cnt));
    chk("wrap_n",  wrap_l, m_wrap);
    chk("sel_n",   sel_l,  3'(~e_sel));
    chk("seg_n",   seg_l,  7'(~e_seg));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    cyc(40);
    load = 1'b1; load_val = 12'h998; cyc(1);
    load = 1'b0; cyc(8);
    load = 1'b1; load_val = 12'hF9F; cyc(1);
    load = 1'b0;
    chk("ld_sat", cnt_h, 12'h999);
    up_dn = 1'b0; load = 1'b1; load_val = 12'h000; cyc(1);
    load = 1'b0; cyc(5);
    load = 1'b1; load_val = 12'h100; cyc(1);
    load = 1'b0; cyc(5);
    chk("borrow", cnt_h, 12'h099);
    load = 1'b1; load_val = 12'h042; cyc(1);
    load = 1'b0; en = 1'b0; cyc(8);
    blank_lz = 1'b1; cyc(8);
    chk("frozen", cnt_h, 12'h042);
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      en = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 63) == 0) up_dn = ~up_dn;
      load = $urandom_range(0, 23) == 0;
      case ($urandom_range(0, 3))
        0: load_val = 12'h999;
        1: load_val = 12'h000;
        default: load_val = 12'($urandom);
      endcase
      if ($urandom_range(0, 127) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        cyc(2);
        rst = 1'b0;
      end
      cyc(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg7_mux_counter.md
Name: seg7_mux_counter

Overview:
Parametrised N-digit BCD up/down counter with a multiplexed 7-segment display driver. It is the next generation of the fixed 3-digit counter/display top used behind the tt_um wrapper, and generalises digit count, count rate, scan rate and output polarity. It adds up/down counting, parallel load, a wrap flag and leading-zero blanking. It drives the shared segment bus (d7sp) and the per-digit transistor selects directly.

Parameters:
NUM_DIGITS, 3, number of BCD digits and transistor select lines (1..8)
TICK_DIV, 1000000, clk cycles per count step (>=1)
REFRESH_DIV, 1000, clk cycles each digit stays selected (>=1)
SEG_ACTIVE_LOW, 0, 1 inverts d7sp (common-anode display)
SEL_ACTIVE_LOW, 0, 1 inverts transistor

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  count enable; low freezes the count and the tick prescaler
up_dn  in  1  1 = count up, 0 = count down; sampled on each tick
load  in  1  synchronous parallel load of load_val
load_val  in  4*NUM_DIGITS  BCD load value, digit 0 (least significant) in [3:0]
blank_lz  in  1  1 = blank leading zero digits
count_bcd  out  4*NUM_DIGITS  current BCD count, registered
wrap  out  1  one-cycle pulse when the count wraps
transistor  out  NUM_DIGITS  one-hot digit select, bit i = digit i
d7sp  out  7  segment bus; d7sp[0]=a ... d7sp[6]=g

Behaviour:
- Reset (async assert; release is synchronous to clk): count_bcd=0, tick prescaler=0, refresh prescaler=0, scan index=0, wrap=0. transistor and d7sp are all inactive, at the level set by the polarity parameters. The first active select appears on the first clk edge after rst deasserts.
- Tick prescaler: counts 0..TICK_DIV-1 while en=1 and holds while en=0. The tick is asserted in the cycle the prescaler equals TICK_DIV-1, and the prescaler then returns to 0. With TICK_DIV=1 there is a tick every enabled cycle.
- Count step on tick:
  - Up: digit 0 increments; a digit going 9->0 carries into the next digit.
  - Down: digit 0 decrements; a digit going 0->9 borrows from the next digit.
  - Up wrap: all 9s -> all 0s, wrap=1 for exactly one cycle, coincident with the new count.
  - Down wrap: all 0s -> all 9s, wrap=1 likewise.
- Load: has priority over the tick. count_bcd<=load_val on the next edge, the tick prescaler is cleared to 0, and no wrap pulse is produced. Any load_val nibble >9 is loaded as 9. load acts regardless of en.
- Digit scan:
  - The refresh prescaler runs continuously, independent of en, counting 0..REFRESH_DIV-1.
  - At terminal count the scan index advances, with wrap NUM_DIGITS-1 -> 0.
- Outputs: transistor and d7sp are registered every cycle from the same scan index and the same count value, so select and segments always change on the same edge. Latency from a count_bcd change to d7sp is 1 cycle while that digit is selected.
- Decode (active-high patterns, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any other value displays all segments off.
- Leading-zero blanking: with blank_lz=1, digit i (i>0) shows segments off when it and every higher digit are 0. Digit 0 is never blanked. transistor remains asserted for a blanked digit.
- Polarity: with SEG_ACTIVE_LOW=1, d7sp is the bitwise inverse of the active-high pattern, including the reset/off states. SEL_ACTIVE_LOW=1 applies the same rule to transistor.
- rst asserted mid-count or mid-scan returns everything to the reset values immediately, with no partial wrap pulse.

Test Plan:
All scenarios use NUM_DIGITS=3, TICK_DIV=4, REFRESH_DIV=2 and active-high polarity unless stated.
1. Reset then en=1, up_dn=1 for 40 cycles -> count_bcd increments every 4 cycles (0x000, 0x001, ..., 0x00A is never seen; 0x009 -> 0x010), wrap=0 throughout.
2. load=1 with load_val=0x998, then up for 8 cycles -> 0x999, then 0x000 with wrap high for exactly 1 cycle; load_val=0xF9F loads as 0x999.
3. Down counting:
   - load 0x000, up_dn=0 -> after the next tick count=0x999 and wrap pulses once.
   - load 0x100 -> next tick gives 0x099.
4. Scan with count=0x042:
   - transistor sequence 001, 010, 100, 001, each held 2 cycles.
   - d7sp shows 1011011, 1100110, 0111111 respectively; with blank_lz=1 the third digit shows 0000000 while transistor=100.
5. load and tick in the same cycle -> the load value wins, the next tick is 4 cycles later, no wrap pulse. en=0 for 20 cycles -> count is frozen and the scan continues.
6. SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=1; rst pulse mid-scan -> during reset transistor=111 and d7sp=1111111. Digit "8" selected -> d7sp=0000000 and transistor bit low.
